crc12_framer: RTL and testbench

CRC12_FRAMER -- requirements
Module: crc12_framer

---
 rtl/crc12_framer.sv | 152 +++++++++++++++
 tb/tb_crc12_framer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc12_framer.sv
// crc12_framer: appends a CRC-12/DECT (poly 0x80F, init 0, MSB-first) to a byte stream.
// Optional feature macro: CRC12_FRAMER_SOF_EN prepends SOF_BYTE to every frame (not CRC'd).
// The output is one register stage; s_ready is combinational from state and m_ready.
module crc12_framer #(
    parameter logic [7:0] SOF_BYTE = 8'hD5
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 12;
    localparam logic [CW-1:0] POLY = 12'h80F;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
`ifdef CRC12_FRAMER_SOF_EN
        SOF    = 3'd1,
`endif
        DATA   = 3'd2,
        CRC_HI = 3'd3,
        CRC_LO = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] crc_q, crc_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic          en_q;
    logic          out_free;
    logic          accept;

`ifndef CRC12_FRAMER_SOF_EN
    // SOF_BYTE has no role without the SOF beat; sink it so it is not left dangling.
    logic unused_sof;
    assign unused_sof = ^SOF_BYTE;
`endif

    // Fold one byte into the CRC, MSB first.
    function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] crc, input logic [DW-1:0] b);
        logic [CW-1:0] c;
        c = crc ^ {b, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            c = c[CW-1] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    // Next-state, CRC and output-register logic.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        out_free  = !m_valid_q || m_ready;
        s_ready   = 1'b0;

`ifdef CRC12_FRAMER_SOF_EN
        if (en_q && state_q == DATA) s_ready = out_free;
`else
        if (en_q && (state_q == IDLE || state_q == DATA)) s_ready = out_free;
`endif
        accept = s_valid && s_ready;

        // Current output byte leaves on handshake unless replaced below.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                crc_d = '0;
`ifdef CRC12_FRAMER_SOF_EN
                if (s_valid) state_d = SOF;
`endif
            end
`ifdef CRC12_FRAMER_SOF_EN
            SOF: begin
                if (out_free) begin
                    m_data_d  = SOF_BYTE;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    state_d   = DATA;
                end
            end
`endif
            DATA: ;
            CRC_HI: begin
                if (out_free) begin
                    m_data_d  = {4'b0000, crc_q[11:8]};
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    state_d   = CRC_LO;
                end
            end
            CRC_LO: begin
                if (out_free) begin
                    m_data_d  = crc_q[7:0];
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    crc_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Payload beat: only possible in IDLE (no SOF) or DATA; crc_q is zero in IDLE.
        if (accept) begin
            m_data_d  = s_data;
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
            crc_d     = crc_step(crc_q, s_data);
            state_d   = s_last ? CRC_HI : DATA;
        end
    end

    // State, CRC and output registers; en_q holds s_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= IDLE;
            crc_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            en_q      <= 1'b1;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_crc12_framer.sv
// Self-checking bench for crc12_framer with a polynomial-division CRC model.
// Honours CRC12_FRAMER_SOF_EN when defined at compile time.
module tb_crc12_framer;

    localparam logic [7:0] SOF_B = 8'hD5;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       arstn;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    int checks = 0;
    int failures = 0;
    int first_out;
    int last_out;

    logic [7:0] pay_q[$];
    beat_t      in_q[$];
    beat_t      exp_q[$];

    crc12_framer #(.SOF_BYTE(SOF_B)) dut (
        .clk    (clk),
        .arstn  (arstn),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_last (s_last),
        .s_ready(s_ready),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_last (m_last),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // CRC as remainder of M(x)*x^12 divided by x^12+x^11+x^3+x^2+x+1.
    function automatic logic [11:0] crc_model();
        int unsigned v = 0;
        foreach (pay_q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                v = (v << 1) | 32'(pay_q[i][b]);
                if ((v & 32'h1000) != 0) v = v ^ 32'h180F;
            end
        end
        for (int k = 0; k < 12; k++) begin
            v = v << 1;
            if ((v & 32'h1000) != 0) v = v ^ 32'h180F;
        end
        return v[11:0];
    endfunction

    function automatic void push_exp(input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endfunction

    function automatic void add_payload();
        beat_t b;
`ifdef CRC12_FRAMER_SOF_EN
        push_exp(SOF_B, 1'b0);
`endif
        foreach (pay_q[i]) begin
            b.data = pay_q[i];
            b.last = (i == pay_q.size() - 1);
            in_q.push_back(b);
            push_exp(pay_q[i], 1'b0);
        end
    endfunction

    function automatic void add_model_crc();
        logic [11:0] c;
        c = crc_model();
        push_exp({4'b0000, c[11:8]}, 1'b0);
        push_exp(c[7:0], 1'b1);
    endfunction

    function automatic void load_check_string();
        string s = "123456789";
        pay_q.delete();
        for (int i = 0; i < s.len(); i++) pay_q.push_back(s[i]);
    endfunction

    // Stream in_q into the DUT and score every output handshake against exp_q.
    // rdy_mode: 0 = m_ready high, 1 = toggle each cycle, 2 = random.
    task automatic drive(input int rdy_mode, input int vld_pct, input int max_cycles);
        int idx = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic prev_last = 1'b0;
        beat_t e;
        first_out = -1;
        last_out = -1;
        while ((idx < in_q.size() || exp_q.size() != 0) && cyc < max_cycles) begin
            @(negedge clk);
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = (cyc % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (idx < in_q.size()) begin
                s_valid = ($urandom_range(0, 99) < vld_pct);
                s_data  = in_q[idx].data;
                s_last  = in_q[idx].last;
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_byte: got d=%h l=%b want none", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.data || m_last !== e.last) begin
                        failures++;
                        $display("FAIL out_byte: got d=%h l=%b want d=%h l=%b",
                                 m_data, m_last, e.data, e.last);
                    end
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (s_valid && s_ready) idx++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            cyc++;
        end
        checks++;
        if (idx != in_q.size() || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drive_timeout: got sent=%0d left=%0d want sent=%0d left=0",
                     idx, exp_q.size(), in_q.size());
        end
        s_valid = 1'b0;
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        arstn = 1'b1; s_valid = 1'b0; m_ready = 1'b1; s_data = 8'hA5; s_last = 1'b0;
        #2 arstn = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data: got %h want 00", m_data); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        repeat (2) @(negedge clk);
        s_valid = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_held_s_ready: got %b want 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_held_m_valid: got %b want 0", m_valid); end
        s_valid = 1'b0;
        arstn = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rel_s_ready: got %b want 0", s_ready); end
        @(posedge clk);
        #1;
        checks++;
`ifdef CRC12_FRAMER_SOF_EN
        if (s_ready !== 1'b0) begin failures++; $display("FAIL post_edge_s_ready: got %b want 0", s_ready); end
`else
        if (s_ready !== 1'b1) begin failures++; $display("FAIL post_edge_s_ready: got %b want 1", s_ready); end
`endif
    endtask

    task automatic test_single_byte();
        pay_q.delete(); pay_q.push_back(8'h01);
        add_payload();
        push_exp(8'h08, 1'b0);
        push_exp(8'h0F, 1'b1);
        drive(0, 100, 50);
    endtask

    task automatic test_throughput();
        load_check_string();
        add_payload();
        push_exp(8'h0F, 1'b0);
        push_exp(8'h5B, 1'b1);
        drive(0, 100, 100);
        checks++;
`ifdef CRC12_FRAMER_SOF_EN
        if (last_out - first_out != 11) begin failures++; $display("FAIL throughput_span: got %0d want 11", last_out - first_out); end
`else
        if (last_out - first_out != 10) begin failures++; $display("FAIL throughput_span: got %0d want 10", last_out - first_out); end
`endif
    endtask

    task automatic test_stall_toggle();
        load_check_string();
        add_payload();
        push_exp(8'h0F, 1'b0);
        push_exp(8'h5B, 1'b1);
        drive(1, 100, 200);
    endtask

`ifdef CRC12_FRAMER_SOF_EN
    task automatic test_sof_zero();
        pay_q.delete(); pay_q.push_back(8'h00);
        add_payload();
        push_exp(8'h00, 1'b0);
        push_exp(8'h00, 1'b1);
        drive(0, 100, 50);
    endtask
`endif

    task automatic test_reset_mid_frame();
        int acc = 0;
        int cyc = 0;
        while (acc < 4 && cyc < 40) begin
            @(negedge clk);
            m_ready = 1'b1; s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0;
            #1;
            if (s_valid && s_ready) acc++;
            cyc++;
        end
        checks++;
        if (acc != 4) begin failures++; $display("FAIL mid_setup: got %0d beats want 4", acc); end
        @(negedge clk);
        s_valid = 1'b0;
        #2 arstn = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_m_valid: got %b want 0", m_valid); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_held: got %b want 0", m_valid); end
        arstn = 1'b1;
        pay_q.delete(); pay_q.push_back(8'h01);
        add_payload();
        push_exp(8'h08, 1'b0);
        push_exp(8'h0F, 1'b1);
        drive(0, 100, 50);
    endtask

    task automatic test_back_to_back();
        pay_q.delete(); pay_q.push_back(8'h01);
        add_payload(); push_exp(8'h08, 1'b0); push_exp(8'h0F, 1'b1);
        add_payload(); push_exp(8'h08, 1'b0); push_exp(8'h0F, 1'b1);
        drive(0, 100, 60);
        checks++;
`ifdef CRC12_FRAMER_SOF_EN
        if (last_out - first_out != 8) begin failures++; $display("FAIL b2b_span: got %0d want 8", last_out - first_out); end
`else
        if (last_out - first_out != 5) begin failures++; $display("FAIL b2b_span: got %0d want 5", last_out - first_out); end
`endif
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int len;
            len = $urandom_range(1, 10);
            pay_q.delete();
            for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
            add_payload();
            add_model_crc();
        end
        drive(2, 70, 4000);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_throughput();
        test_stall_toggle();
`ifdef CRC12_FRAMER_SOF_EN
        test_sof_zero();
`endif
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
